// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, GF(2^8) helpers, round constants,
// FSM state type and column-major byte addressing.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round numbers outside 1..10 yield 0; they never reach a real round.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (round == 4'(i + 1)) r = RCON[i];
    end
    return r;
  endfunction

  // LSB position of byte (column c, row r) in a 128-bit block; byte 0 is the MSB.
  function automatic int byte_pos(input int c, input int r);
    return 120 - 32 * c - 8 * r;
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional
// MixColumns (skipped on the final round), then AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_round_i,
  output logic [127:0] state_o
);

  logic [127:0] sub_w;
  logic [127:0] shift_w;
  logic [127:0] mix_w;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      for (genvar gj = 0; gj < 4; gj++) begin : g_row
        assign sub_w[byte_pos(gi, gj) +: 8]   = sbox(state_i[byte_pos(gi, gj) +: 8]);
        // Row gj rotates left by gj columns.
        assign shift_w[byte_pos(gi, gj) +: 8] = sub_w[byte_pos((gi + gj) % 4, gj) +: 8];
      end

      logic [7:0] a0, a1, a2, a3;
      assign a0 = shift_w[byte_pos(gi, 0) +: 8];
      assign a1 = shift_w[byte_pos(gi, 1) +: 8];
      assign a2 = shift_w[byte_pos(gi, 2) +: 8];
      assign a3 = shift_w[byte_pos(gi, 3) +: 8];

      assign mix_w[byte_pos(gi, 0) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mix_w[byte_pos(gi, 1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mix_w[byte_pos(gi, 2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mix_w[byte_pos(gi, 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  assign state_o = (last_round_i ? shift_w : mix_w) ^ rk_i;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock with the key
// schedule expanded on the fly alongside the datapath.
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  aes_fsm_e     fsm_q;
  logic [3:0]   round_q;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  logic [127:0] rk_d;
  logic [127:0] state_d;
  logic [31:0]  w0, w1, w2, w3, t_w;
  logic [31:0]  n0, n1, n2, n3;

  // Key expansion: RotWord, SubWord and rcon on the last word, then chained XORs.
  assign {w0, w1, w2, w3} = rk_q;
  assign t_w = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rcon(round_q), 24'h000000};
  assign n0 = w0 ^ t_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign rk_d = {n0, n1, n2, n3};

  aes_enc_round u_round (
    .state_i      (state_q),
    .rk_i         (rk_d),
    .last_round_i (round_q == LAST_ROUND),
    .state_o      (state_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd0;
      state_q     <= '0;
      rk_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            state_q    <= plaintext ^ key;
            rk_q       <= key;
            round_q    <= 4'd1;
            fsm_q      <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          if (round_q == 4'd0 || round_q > LAST_ROUND) begin
            fsm_q      <= IDLE;
            round_q    <= 4'd0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            if (round_q == LAST_ROUND) begin
              fsm_q       <= DONE;
              round_q     <= 4'd0;
              out_valid_q <= 1'b1;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            if (ZEROIZE) begin
              state_q <= '0;
              rk_q    <= '0;
            end
          end
        end
        default: begin
          fsm_q       <= IDLE;
          round_q     <= 4'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign ciphertext = state_q;

endmodule
